// File: rtl/ryu_motion_ctrl_if.sv
// Control and render bus between the keyboard/frame logic and the Ryu motion block.
// The master drives the frame strobe and keys; the slave drives sprite position, select and status.
interface ryu_motion_ctrl_if;
    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_punch;
    logic       key_jump;
    logic [9:0] RyuX;
    logic [9:0] RyuY;
    logic [2:0] sprite;
    logic       punch_strobe;
    logic       airborne;

    modport master (
        output frame_tick, key_left, key_right, key_punch, key_jump,
        input  RyuX, RyuY, sprite, punch_strobe, airborne
    );

    modport slave (
        input  frame_tick, key_left, key_right, key_punch, key_jump,
        output RyuX, RyuY, sprite, punch_strobe, airborne
    );
endinterface

// File: rtl/ryu_motion_ctrl.sv
// Ryu player motion: walk, timed punch and ballistic jump, advanced once per frame strobe.
// Drives the sprite renderer position and select from decoded keyboard controls.
module ryu_motion_ctrl #(
    parameter int X_START      = 100,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 560,
    parameter int GROUND_Y     = 300,
    parameter int STEP         = 2,
    parameter int PUNCH_FRAMES = 12,
    parameter int JUMP_VEL     = 16,
    parameter int GRAVITY      = 1
) (
    input  logic               vga_clk,
    input  logic               Reset,
    ryu_motion_ctrl_if.slave   bus
);

    localparam int VY_W  = 7;
    localparam int CNT_W = (PUNCH_FRAMES > 1) ? $clog2(PUNCH_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUNCH = 2'd1,
        JUMP  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [9:0]               x_q, x_d;
    logic [9:0]               y_q, y_d;
    logic signed [VY_W-1:0]   vy_q, vy_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               sprite_q, sprite_d;
    logic                     strobe_q, strobe_d;
    logic                     airborne_q, airborne_d;
    logic                     armed_q, armed_d;

    logic [9:0]               x_walk;
    logic signed [10:0]       y_calc;

    // Horizontal step saturates on the bounds; simultaneous left+right cancels out.
    always_comb begin
        x_walk = x_q;
        if (bus.key_left && !bus.key_right) begin
            if ({1'b0, x_q} < 11'(X_MIN + STEP))
                x_walk = 10'(X_MIN);
            else
                x_walk = x_q - 10'(STEP);
        end else if (bus.key_right && !bus.key_left) begin
            if ({1'b0, x_q} > 11'(X_MAX - STEP))
                x_walk = 10'(X_MAX);
            else
                x_walk = x_q + 10'(STEP);
        end
    end

    // Upward velocity is positive, so the new height subtracts it from the screen Y.
    assign y_calc = $signed({1'b0, y_q}) - $signed({{(11 - VY_W){vy_q[VY_W-1]}}, vy_q});

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        cnt_d      = cnt_q;
        sprite_d   = sprite_q;
        airborne_d = airborne_q;
        armed_d    = armed_q;
        strobe_d   = 1'b0;

        if (bus.frame_tick) begin
            if (!bus.key_punch)
                armed_d = 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.key_jump) begin
                        state_d    = JUMP;
                        vy_d       = VY_W'(JUMP_VEL);
                        sprite_d   = 3'd2;
                        airborne_d = 1'b1;
                    end else if (bus.key_punch && armed_q) begin
                        state_d  = PUNCH;
                        cnt_d    = CNT_W'(PUNCH_FRAMES - 1);
                        sprite_d = 3'd1;
                        strobe_d = 1'b1;
                        armed_d  = 1'b0;
                    end else begin
                        x_d = x_walk;
                    end
                end
                PUNCH: begin
                    if (cnt_q == '0) begin
                        state_d  = IDLE;
                        sprite_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                JUMP: begin
                    x_d  = x_walk;
                    vy_d = vy_q - VY_W'(GRAVITY);
                    if (vy_q[VY_W-1] && (y_calc >= $signed(11'(GROUND_Y)))) begin
                        y_d        = 10'(GROUND_Y);
                        state_d    = IDLE;
                        sprite_d   = 3'd0;
                        airborne_d = 1'b0;
                        vy_d       = '0;
                    end else if (y_calc[10]) begin
                        y_d = '0;
                    end else begin
                        y_d = y_calc[9:0];
                    end
                end
                default: begin
                    state_d    = IDLE;
                    sprite_d   = 3'd0;
                    airborne_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            x_q        <= 10'(X_START);
            y_q        <= 10'(GROUND_Y);
            vy_q       <= '0;
            cnt_q      <= '0;
            sprite_q   <= 3'd0;
            strobe_q   <= 1'b0;
            airborne_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            cnt_q      <= cnt_d;
            sprite_q   <= sprite_d;
            strobe_q   <= strobe_d;
            airborne_q <= airborne_d;
            armed_q    <= armed_d;
        end
    end

    assign bus.RyuX         = x_q;
    assign bus.RyuY         = y_q;
    assign bus.sprite       = sprite_q;
    assign bus.punch_strobe = strobe_q;
    assign bus.airborne     = airborne_q;

endmodule

// File: tb/tb_ryu_motion_ctrl.sv
// Directed bench for ryu_motion_ctrl: walk, saturation, punch timing, jump arc and reset.
// A second instance starting at X=559 covers the right-edge saturation.
module tb_ryu_motion_ctrl;

    logic vga_clk = 1'b0;
    logic Reset   = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   tick_num     = 0;

    ryu_motion_ctrl_if bus ();
    ryu_motion_ctrl_if bus2 ();

    assign bus2.frame_tick = bus.frame_tick;
    assign bus2.key_left   = bus.key_left;
    assign bus2.key_right  = bus.key_right;
    assign bus2.key_punch  = bus.key_punch;
    assign bus2.key_jump   = bus.key_jump;

    ryu_motion_ctrl dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    ryu_motion_ctrl #(.X_START(559)) dut_edge (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus2)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        tests_run++;
        if (obs != exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_keys(input logic l, input logic r, input logic p, input logic j);
        bus.key_left  = l;
        bus.key_right = r;
        bus.key_punch = p;
        bus.key_jump  = j;
    endtask

    // One idle cycle, then a one-cycle frame strobe; returns at the following negedge.
    task automatic tick();
        @(negedge vga_clk);
        bus.frame_tick = 1'b1;
        @(negedge vga_clk);
        bus.frame_tick = 1'b0;
        tick_num++;
        $display("[TB] tick %0d keys(lrpj)=%b%b%b%b X=%0d Y=%0d sprite=%0d strobe=%b air=%b",
                 tick_num, bus.key_left, bus.key_right, bus.key_punch, bus.key_jump,
                 bus.RyuX, bus.RyuY, bus.sprite, bus.punch_strobe, bus.airborne);
    endtask

    int jump_rise [8] = '{284, 269, 255, 242, 230, 219, 209, 200};
    int x_exp;

    initial begin
        bus.frame_tick = 1'b0;
        set_keys(0, 0, 0, 0);
        repeat (3) @(negedge vga_clk);
        Reset = 1'b0;

        check("rst_x", bus.RyuX, 100);
        check("rst_y", bus.RyuY, 300);
        check("rst_sprite", bus.sprite, 0);
        check("rst_strobe", bus.punch_strobe, 0);
        check("rst_air", bus.airborne, 0);
        check("rst_edge_x", bus2.RyuX, 559);

        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_x", bus.RyuX, 100);
            check("idle_y", bus.RyuY, 300);
            check("idle_sprite", bus.sprite, 0);
            check("idle_air", bus.airborne, 0);
        end

        // Right walk, with the edge instance saturating at 560.
        set_keys(0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("right_x", bus.RyuX, 100 + 2 * i);
            check("edge_x", bus2.RyuX, 560);
        end
        set_keys(1, 1, 0, 0);
        tick();
        check("both_x", bus.RyuX, 106);
        set_keys(1, 0, 0, 0);
        tick();
        check("left_x", bus.RyuX, 104);

        // Punch held for 20 ticks with right also held.
        set_keys(0, 1, 1, 0);
        x_exp = 104;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i > 13) x_exp += 2;
            check("punch_strobe", bus.punch_strobe, (i == 1) ? 1 : 0);
            check("punch_sprite", bus.sprite, (i <= 12) ? 1 : 0);
            check("punch_x", bus.RyuX, x_exp);
            if (i == 1) begin
                @(negedge vga_clk);
                check("strobe_one_cycle", bus.punch_strobe, 0);
            end
        end
        set_keys(0, 0, 0, 0);
        tick();
        check("release_x", bus.RyuX, 118);

        // Single jump pulse, full arc.
        set_keys(0, 0, 0, 1);
        tick();
        check("jump_entry_sprite", bus.sprite, 2);
        check("jump_entry_air", bus.airborne, 1);
        check("jump_entry_y", bus.RyuY, 300);
        set_keys(0, 0, 0, 0);
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (i <= 4) check("jump_rise_y", bus.RyuY, jump_rise[i-1]);
            if (i == 16 || i == 17) check("jump_apex_y", bus.RyuY, 164);
            if (i == 32) begin
                check("jump_fall_y", bus.RyuY, 284);
                check("jump_fall_air", bus.airborne, 1);
            end
        end
        check("land_y", bus.RyuY, 300);
        check("land_sprite", bus.sprite, 0);
        check("land_air", bus.airborne, 0);
        check("land_x", bus.RyuX, 118);

        // Jump and punch on the same tick, then drift right while rising.
        set_keys(0, 1, 1, 1);
        tick();
        check("jp_sprite", bus.sprite, 2);
        check("jp_strobe", bus.punch_strobe, 0);
        check("jp_entry_x", bus.RyuX, 118);
        set_keys(0, 1, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("jp_y", bus.RyuY, jump_rise[i-1]);
            check("jp_x", bus.RyuX, 118 + 2 * i);
            check("jp_strobe_air", bus.punch_strobe, 0);
        end

        // Reset mid-jump, asserted together with a tick.
        @(negedge vga_clk);
        Reset = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge vga_clk);
        Reset = 1'b0;
        bus.frame_tick = 1'b0;
        check("midrst_y", bus.RyuY, 300);
        check("midrst_x", bus.RyuX, 100);
        check("midrst_sprite", bus.sprite, 0);
        check("midrst_air", bus.airborne, 0);
        $display("[TB] reset mid-jump X=%0d Y=%0d sprite=%0d", bus.RyuX, bus.RyuY, bus.sprite);

        // Keys pressed but no frame strobe: nothing may move.
        set_keys(0, 1, 1, 1);
        repeat (100) @(negedge vga_clk);
        check("hold_x", bus.RyuX, 100);
        check("hold_y", bus.RyuY, 300);
        check("hold_sprite", bus.sprite, 0);
        check("hold_strobe", bus.punch_strobe, 0);
        $display("[TB] 100 cycles without tick X=%0d Y=%0d sprite=%0d", bus.RyuX, bus.RyuY, bus.sprite);

        // Punch armed straight out of reset.
        set_keys(0, 0, 1, 0);
        tick();
        check("armed_rst_strobe", bus.punch_strobe, 1);
        check("armed_rst_sprite", bus.sprite, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ryu_motion_ctrl.md
Name: ryu_motion_ctrl

Overview:
- Player-side game-logic block that drives the Ryu sprite renderer's input interface.
- Converts decoded keyboard controls into the renderer inputs: RyuX, RyuY and the 3-bit sprite select (0 standing, 1 punching, 2 jumping).
- Runs on the pixel clock; state advances only on a one-cycle frame strobe, once per video frame.
- Holds the per-character movement, punch-duration and jump-physics state.

Parameters:
- X_START, 100: RyuX after reset.
- X_MIN, 0: leftmost legal RyuX.
- X_MAX, 560: rightmost legal RyuX (640 minus sprite width).
- GROUND_Y, 300: RyuY when standing.
- STEP, 2: horizontal pixels moved per frame.
- PUNCH_FRAMES, 12: frames the punch sprite is held.
- JUMP_VEL, 16: initial upward velocity, pixels/frame.
- GRAVITY, 1: velocity decrement per frame.

Ports:
- vga_clk  in  1  sole clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame; all state updates occur only on cycles where this is 1.
- key_left  in  1  move-left held.
- key_right  in  1  move-right held.
- key_punch  in  1  punch held.
- key_jump  in  1  jump held.
- RyuX  out  10  sprite X origin.
- RyuY  out  10  sprite Y origin.
- sprite  out  3  renderer select; only 3'd0, 3'd1 or 3'd2 is ever driven.
- punch_strobe  out  1  one-cycle pulse when a punch starts (hit detection).
- airborne  out  1  1 while in JUMP.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset has priority over frame_tick.
  - On reset: RyuX=X_START, RyuY=GROUND_Y, sprite=0, punch_strobe=0, airborne=0, state=IDLE, vy=0, punch counter=0, punch_armed=1.
- Timing:
  - All outputs are registered.
  - The effect of a tick is visible on the cycle after the tick cycle.
  - Key inputs are sampled only on tick cycles.
  - With frame_tick low, every register holds.
- punch_armed:
  - Cleared when a punch starts.
  - Set on any tick where key_punch=0.
  - A held punch key therefore never re-triggers.
- State IDLE (sprite=0), on a tick, priority jump > punch > walk:
  - key_jump=1: enter JUMP, vy=JUMP_VEL, sprite=2, airborne=1. RyuY is not moved on the entry tick.
  - Else key_punch=1 and punch_armed=1: enter PUNCH, counter=PUNCH_FRAMES-1, sprite=1, punch_strobe=1 for exactly one cycle.
  - Else walk:
    - Exactly one of left/right asserted: RyuX moves by STEP in that direction, saturating at X_MIN/X_MAX.
    - Both or neither asserted: no move.
- State PUNCH:
  - No horizontal motion; all keys are ignored except for punch_armed tracking.
  - Each tick: if counter==0, return to IDLE with sprite=0; else decrement counter.
  - Sprite 1 is therefore shown for exactly PUNCH_FRAMES ticks.
- State JUMP:
  - Horizontal walk applies as in IDLE; punch is ignored.
  - Each tick compute y_next = RyuY - vy in 11-bit signed arithmetic (vy is signed, 6 bits minimum), then vy = vy - GRAVITY.
  - Falling and y_next >= GROUND_Y (vy < 0 before the update): RyuY=GROUND_Y, state=IDLE, sprite=0, airborne=0, vy=0.
  - y_next < 0: clamp RyuY to 0; vy continues to decay.
  - Otherwise RyuY = y_next.
- Saturation:
  - Moves that would cross X_MIN/X_MAX land exactly on the bound; they never wrap.
  - The 10-bit RyuX/RyuY outputs never wrap.
- Reset mid-punch or mid-jump: immediately returns to the reset values above, with no partial update.
- punch_strobe is 0 on every cycle except the one following a punch-start tick.

Test Plan:
- Reset, then 5 ticks with no keys -> RyuX=100, RyuY=300, sprite=0, airborne=0 throughout.
- key_right held 3 ticks -> RyuX 102, 104, 106. With RyuX=559, one right tick -> 560, a further tick -> 560. Left and right held together -> no change.
- key_punch held for 20 ticks:
  - punch_strobe is high exactly one cycle.
  - sprite=1 for 12 ticks, then 0.
  - No re-punch until key_punch is low on a tick.
  - key_right held during the punch -> RyuX unchanged.
- key_jump pulsed on one tick with no other keys:
  - sprite=2 and airborne=1 after the entry tick.
  - RyuY after ticks 1-4 = 284, 269, 255, 242.
  - Apex 164 held over ticks 16-17.
  - After tick 33: RyuY=300, sprite=0, airborne=0.
- Jump and punch pressed on the same tick -> JUMP entered, punch_strobe stays 0. Right held during the jump -> RyuX +2 per tick.
- Reset asserted mid-jump at RyuY=200 -> next cycle RyuY=300, RyuX=100, sprite=0. frame_tick held low for 100 cycles -> outputs unchanged.
